inv_mix_columns_iter: RTL

Iterative AES InvMixColumns unit for the decryption datapath. It accepts a full 128-bit AES state over a valid/ready handshake and multiplies each 32-bit column by the inverse MixColumns matrix {0E,0B,0D,09} over GF(2^8), mod 0x11B. It processes COLS_PER_CYCLE columns per clock, holds the result until downstream accepts it, and sits between InvShiftRows/InvSubBytes and AddRoundKey in the decrypt round loop.

---
 rtl/inv_mix_columns_iter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: transforms a 128-bit state COLS_PER_CYCLE columns
// per clock behind a valid/ready handshake and holds the result until taken.
module inv_mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gen_bad_cols
        $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // For 4 columns per cycle the step wraps to 0 and the first column is also the last.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul_0e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3),
                mul_09(a0) ^ mul_0e(a1) ^ mul_0b(a2) ^ mul_0d(a3),
                mul_0d(a0) ^ mul_09(a1) ^ mul_0e(a2) ^ mul_0b(a3),
                mul_0b(a0) ^ mul_0d(a1) ^ mul_09(a2) ^ mul_0e(a3)};
    endfunction

    state_t       state_r;
    state_t       state_s;
    logic [127:0] work_r;
    logic [127:0] work_s;
    logic [127:0] xform_s;
    logic [1:0]   col_idx_r;
    logic [1:0]   col_idx_s;
    logic         out_valid_r;
    logic         out_valid_s;
    logic [127:0] out_data_r;
    logic [127:0] out_data_s;
    logic         busy_r;
    logic         can_take_s;
    logic         accept_s;

    assign can_take_s = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign in_ready   = !rst && can_take_s;
    assign accept_s   = in_valid && in_ready;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign busy       = busy_r;

    // Working state with the current group of columns replaced by their transform.
    always_comb begin
        xform_s = work_r;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            xform_s[7'd127 - {col_idx_r + 2'(k), 5'd0} -: 32] =
                inv_mix_col(work_r[7'd127 - {col_idx_r + 2'(k), 5'd0} -: 32]);
        end
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE handshake FSM.
    always_comb begin
        state_s     = state_r;
        work_s      = work_r;
        col_idx_s   = col_idx_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s   = BUSY;
                    work_s    = in_data;
                    col_idx_s = 2'd0;
                end else begin
                    state_s   = IDLE;
                end
            end
            BUSY: begin
                work_s    = xform_s;
                col_idx_s = col_idx_r + COL_STEP;
                if (col_idx_r == LAST_COL) begin
                    state_s     = DONE;
                    out_valid_s = 1'b1;
                    out_data_s  = xform_s;
                end else begin
                    state_s     = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    if (accept_s) begin
                        state_s   = BUSY;
                        work_s    = in_data;
                        col_idx_s = 2'd0;
                    end else begin
                        state_s   = IDLE;
                    end
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s     = IDLE;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State, working-state and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            work_r      <= 128'd0;
            col_idx_r   <= 2'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= 128'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            work_r      <= work_s;
            col_idx_r   <= col_idx_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            busy_r      <= (state_s == BUSY);
        end
    end

endmodule
